// File: rtl/bus_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : bus_frame_receiver
// Description : Receive end of the shared serial bus. Frames arrive MSB
//               first at one bit per clock:
//                 start '1' | mod[1:0] | addr[3:0] | data[N-1:0] | crc[3:0]
//               with N = 8/16/32/64 for mod = 0/1/2/3. Frames addressed to
//               MY_ADDR are CRC-4 checked (x^4+x+1, init 0, over mod, addr
//               and data). A good frame updates data_out/mod_out and pulses
//               frame_valid. A bad frame pulses crc_err. Both counters
//               saturate.
// Ports       : clock       - single clock, rising edge
//               reset_n     - asynchronous active-low reset
//               bus_in      - serial bus line, idle low
//               data_out    - last accepted payload, zero-extended to 64 bits
//               mod_out     - mode of the last accepted frame
//               frame_valid - 1-cycle pulse, good frame for this receiver
//               crc_err     - 1-cycle pulse, CRC mismatch on a frame for us
//               busy        - high while a frame is being received
//               frame_cnt   - saturating count of good frames
//               err_cnt     - saturating count of CRC-failed frames
// Config      : BUS_RX_BROADCAST_EN - when defined, address 4'hF is also
//               accepted as a broadcast address.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_frame_receiver #(
    parameter logic [3:0] MY_ADDR = 4'd1,
    parameter int         CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             bus_in,
    output logic [63:0]      data_out,
    output logic [1:0]       mod_out,
    output logic             frame_valid,
    output logic             crc_err,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MOD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_CRC  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [6:0]        bit_cnt_q;     // position inside the current field
    logic [1:0]        mod_q;
    logic [3:0]        addr_q;
    logic [63:0]       shift_q;       // data field, shifted in from the LSB
    logic [3:0]        crc_q;         // running CRC over mod/addr/data
    logic [3:0]        rx_crc_q;      // CRC bits received so far

    // Registered outputs
    logic [63:0]       data_out_q;
    logic [1:0]        mod_out_q;
    logic              frame_valid_q;
    logic              crc_err_q;
    logic              busy_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [3:0]        crc_d;         // CRC after absorbing the current bit
    logic [3:0]        rx_crc_d;      // complete received CRC on its last bit
    logic [6:0]        data_last_d;   // index of the last data bit (N-1)
    logic              addr_match_d;
    logic              crc_ok_d;

    // Serial CRC-4 step: feedback is the incoming bit XOR the top bit.
    always_comb begin
        crc_d = {crc_q[2:0], 1'b0} ^ ((bus_in ^ crc_q[3]) ? 4'h3 : 4'h0);
    end

    always_comb begin
        rx_crc_d = {rx_crc_q[2:0], bus_in};
        crc_ok_d = (rx_crc_d == crc_q);
    end

    always_comb begin
        case (mod_q)
            2'd0:    data_last_d = 7'd7;
            2'd1:    data_last_d = 7'd15;
            2'd2:    data_last_d = 7'd31;
            default: data_last_d = 7'd63;
        endcase
    end

`ifdef BUS_RX_BROADCAST_EN
    // Broadcast frames are handled exactly like frames for our own address.
    always_comb begin
        addr_match_d = (addr_q == MY_ADDR) || (addr_q == 4'hF);
    end
`else
    always_comb begin
        addr_match_d = (addr_q == MY_ADDR);
    end
`endif

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= 7'd0;
            mod_q         <= 2'd0;
            addr_q        <= 4'd0;
            shift_q       <= 64'd0;
            crc_q         <= 4'd0;
            rx_crc_q      <= 4'd0;
            data_out_q    <= 64'd0;
            mod_out_q     <= 2'd0;
            frame_valid_q <= 1'b0;
            crc_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            // Result strobes last exactly one cycle.
            frame_valid_q <= 1'b0;
            crc_err_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus_in) begin
                        // Start bit: clear the per-frame state so that the
                        // upper data bits read as zero for short frames.
                        state_q   <= S_MOD;
                        bit_cnt_q <= 7'd0;
                        mod_q     <= 2'd0;
                        addr_q    <= 4'd0;
                        shift_q   <= 64'd0;
                        crc_q     <= 4'd0;
                        rx_crc_q  <= 4'd0;
                        busy_q    <= 1'b1;
                    end
                end

                S_MOD: begin
                    mod_q <= {mod_q[0], bus_in};
                    crc_q <= crc_d;
                    if (bit_cnt_q == 7'd1) begin
                        state_q   <= S_ADDR;
                        bit_cnt_q <= 7'd0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 7'd1;
                    end
                end

                S_ADDR: begin
                    addr_q <= {addr_q[2:0], bus_in};
                    crc_q  <= crc_d;
                    if (bit_cnt_q == 7'd3) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= 7'd0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 7'd1;
                    end
                end

                S_DATA: begin
                    shift_q <= {shift_q[62:0], bus_in};
                    crc_q   <= crc_d;
                    if (bit_cnt_q == data_last_d) begin
                        state_q   <= S_CRC;
                        bit_cnt_q <= 7'd0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 7'd1;
                    end
                end

                S_CRC: begin
                    // The computed CRC is frozen here; only the received
                    // checksum keeps shifting.
                    rx_crc_q <= rx_crc_d;
                    if (bit_cnt_q == 7'd3) begin
                        // Back to IDLE on the last CRC bit, so a start bit
                        // in the following (pulse) cycle is accepted.
                        state_q   <= S_IDLE;
                        bit_cnt_q <= 7'd0;
                        busy_q    <= 1'b0;
                        if (addr_match_d) begin
                            if (crc_ok_d) begin
                                frame_valid_q <= 1'b1;
                                data_out_q    <= shift_q;
                                mod_out_q     <= mod_q;
                                if (frame_cnt_q != {CNT_W{1'b1}}) begin
                                    frame_cnt_q <= frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                                end
                            end else begin
                                crc_err_q <= 1'b1;
                                if (err_cnt_q != {CNT_W{1'b1}}) begin
                                    err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                                end
                            end
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 7'd1;
                    end
                end

                default: begin
                    state_q   <= S_IDLE;
                    bit_cnt_q <= 7'd0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_out    = data_out_q;
    assign mod_out     = mod_out_q;
    assign frame_valid = frame_valid_q;
    assign crc_err     = crc_err_q;
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_frame_receiver
// Description : Self-checking bench for bus_frame_receiver. A table of frames
//               with hand-written expected results is applied in sequence,
//               followed by directed sequences for reset, back-to-back
//               frames, mid-frame reset and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_frame_receiver;

    localparam int C_CNT_W = 8;

    logic               r_clock;
    logic               r_reset_n;
    logic               r_bus_in;
    logic [63:0]        w_data_out;
    logic [1:0]         w_mod_out;
    logic               w_frame_valid;
    logic               w_crc_err;
    logic               w_busy;
    logic [C_CNT_W-1:0] w_frame_cnt;
    logic [C_CNT_W-1:0] w_err_cnt;

    int n_cmp;
    int n_bad;

    bus_frame_receiver #(
        .MY_ADDR (4'd1),
        .CNT_W   (C_CNT_W)
    ) u_dut (
        .clock       (r_clock),
        .reset_n     (r_reset_n),
        .bus_in      (r_bus_in),
        .data_out    (w_data_out),
        .mod_out     (w_mod_out),
        .frame_valid (w_frame_valid),
        .crc_err     (w_crc_err),
        .busy        (w_busy),
        .frame_cnt   (w_frame_cnt),
        .err_cnt     (w_err_cnt)
    );

    initial r_clock = 1'b0;
    always #5 r_clock = ~r_clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference CRC-4 (x^4+x+1, init 0) over mod, addr and data bits.
    function automatic logic [3:0] crc4(input logic [1:0] m, input logic [3:0] a,
                                        input logic [63:0] d);
        logic [3:0] c;
        logic       fb;
        int         n;
        c = 4'h0;
        n = 8 << m;
        for (int i = 1; i >= 0; i--) begin
            fb = m[i] ^ c[3];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        for (int i = 3; i >= 0; i--) begin
            fb = a[i] ^ c[3];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[3];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return c;
    endfunction

    // Drives one frame, starting in the current cycle (cycle 0 = start bit).
    // Outputs are sampled 1 ns after each edge; after the edge that samples
    // bit k the design shows cycle k+1. Returns at cycle L (frame length).
    task automatic send_frame(input logic [1:0] m, input logic [3:0] a,
                              input logic [63:0] d, input logic [3:0] c,
                              output int v_at, output int e_at,
                              output int n_v, output int n_e,
                              output int busy_bad, output int both);
        logic q[$];
        int   n;
        int   len;
        n = 8 << m;
        q.push_back(1'b1);
        for (int i = 1; i >= 0; i--) q.push_back(m[i]);
        for (int i = 3; i >= 0; i--) q.push_back(a[i]);
        for (int i = n - 1; i >= 0; i--) q.push_back(d[i]);
        for (int i = 3; i >= 0; i--) q.push_back(c[i]);
        len = q.size();
        v_at = 0; e_at = 0; n_v = 0; n_e = 0; busy_bad = 0; both = 0;
        for (int k = 0; k < len; k++) begin
            r_bus_in = q[k];
            @(posedge r_clock);
            #1;
            if (w_frame_valid) begin n_v++; v_at = k + 1; end
            if (w_crc_err)     begin n_e++; e_at = k + 1; end
            if (w_frame_valid && w_crc_err) both++;
            if ((k + 1 < len) && !w_busy) busy_bad++;
            if ((k + 1 == len) && w_busy) busy_bad++;
        end
    endtask

    task automatic idle_cycles(input int n);
        r_bus_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge r_clock);
            #1;
        end
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [3:0]  a;
        logic [63:0] d;
        logic [3:0]  cx;    // XORed into the model CRC to corrupt it
        logic        ev;    // expect frame_valid
        logic        ee;    // expect crc_err
        logic [63:0] edata;
        logic [1:0]  emod;
        int          efc;
        int          eec;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int v_at, e_at, n_v, n_e, busy_bad, both, len, busy_hi;
        int fc0;
        n_cmp     = 0;
        n_bad     = 0;
        r_reset_n = 1'b0;
        r_bus_in  = 1'b0;

        //            m     a      d                        cx    ev    ee    edata                    emod  fc ec
        vecs[0] = '{2'd0, 4'h1, 64'h01,                  4'h0, 1'b1, 1'b0, 64'h01,                  2'd0, 1, 0};
        vecs[1] = '{2'd0, 4'h1, 64'h01,                  4'h1, 1'b0, 1'b1, 64'h01,                  2'd0, 1, 1};
        vecs[2] = '{2'd0, 4'h2, 64'h5A,                  4'h0, 1'b0, 1'b0, 64'h01,                  2'd0, 1, 1};
        vecs[3] = '{2'd1, 4'h1, 64'hA5C3,                4'h0, 1'b1, 1'b0, 64'hA5C3,                2'd1, 2, 1};
        vecs[4] = '{2'd2, 4'h1, 64'h12345678,            4'h0, 1'b1, 1'b0, 64'h12345678,            2'd2, 3, 1};
        vecs[5] = '{2'd3, 4'h1, 64'hDEADBEEF_CAFEF00D,   4'h0, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D,   2'd3, 4, 1};
        vecs[6] = '{2'd2, 4'h1, 64'hFFFFFFFF,            4'h8, 1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D,   2'd3, 4, 2};
        vecs[7] = '{2'd3, 4'h3, 64'h0123456789ABCDEF,    4'h0, 1'b0, 1'b0, 64'hDEADBEEF_CAFEF00D,   2'd3, 4, 2};
        vecs[8] = '{2'd1, 4'h1, 64'h0000,                4'h0, 1'b1, 1'b0, 64'h0,                   2'd1, 5, 2};
`ifdef BUS_RX_BROADCAST_EN
        vecs[9] = '{2'd0, 4'hF, 64'h77,                  4'h0, 1'b1, 1'b0, 64'h77,                  2'd0, 6, 2};
`else
        vecs[9] = '{2'd0, 4'hF, 64'h77,                  4'h0, 1'b0, 1'b0, 64'h0,                   2'd1, 5, 2};
`endif

        // ---------------- Reset, idle bus for 20 cycles ----------------
        repeat (3) @(posedge r_clock);
        @(negedge r_clock);
        r_reset_n = 1'b1;
        busy_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge r_clock);
            #1;
            if (w_busy || w_frame_valid || w_crc_err) busy_hi++;
        end
        check("idle_busy_or_pulse_cycles", 64'(busy_hi), 64'd0);
        check("reset_data_out", w_data_out, 64'd0);
        check("reset_mod_out", 64'(w_mod_out), 64'd0);
        check("reset_frame_cnt", 64'(w_frame_cnt), 64'd0);
        check("reset_err_cnt", 64'(w_err_cnt), 64'd0);

        // ---------------- Table of frames ----------------
        for (int i = 0; i < 10; i++) begin
            len = 11 + (8 << vecs[i].m);
            send_frame(vecs[i].m, vecs[i].a, vecs[i].d,
                       crc4(vecs[i].m, vecs[i].a, vecs[i].d) ^ vecs[i].cx,
                       v_at, e_at, n_v, n_e, busy_bad, both);
            check($sformatf("v%0d_valid_count", i), 64'(n_v), 64'(vecs[i].ev));
            check($sformatf("v%0d_err_count", i), 64'(n_e), 64'(vecs[i].ee));
            if (vecs[i].ev) check($sformatf("v%0d_valid_latency", i), 64'(v_at), 64'(len));
            if (vecs[i].ee) check($sformatf("v%0d_err_latency", i), 64'(e_at), 64'(len));
            check($sformatf("v%0d_data_out", i), w_data_out, vecs[i].edata);
            check($sformatf("v%0d_mod_out", i), 64'(w_mod_out), 64'(vecs[i].emod));
            check($sformatf("v%0d_frame_cnt", i), 64'(w_frame_cnt), 64'(vecs[i].efc));
            check($sformatf("v%0d_err_cnt", i), 64'(w_err_cnt), 64'(vecs[i].eec));
            check($sformatf("v%0d_busy_profile", i), 64'(busy_bad), 64'd0);
            check($sformatf("v%0d_both_pulses", i), 64'(both), 64'd0);
            idle_cycles(1);
            check($sformatf("v%0d_pulse_width", i), 64'(w_frame_valid | w_crc_err), 64'd0);
            idle_cycles(2);
        end

        // ---------------- Foreign frame then zero-gap good frame ----------------
        fc0 = int'(w_frame_cnt);
        send_frame(2'd0, 4'h2, 64'h33, crc4(2'd0, 4'h2, 64'h33),
                   v_at, e_at, n_v, n_e, busy_bad, both);
        check("b2b_foreign_pulses", 64'(n_v + n_e), 64'd0);
        check("b2b_foreign_busy", 64'(busy_bad), 64'd0);
        send_frame(2'd0, 4'h1, 64'hC4, crc4(2'd0, 4'h1, 64'hC4),
                   v_at, e_at, n_v, n_e, busy_bad, both);
        check("b2b_good_latency", 64'(v_at), 64'd19);
        check("b2b_good_data", w_data_out, 64'hC4);
        check("b2b_good_frame_cnt", 64'(w_frame_cnt), 64'(fc0 + 1));
        idle_cycles(3);

        // ---------------- Reset in the middle of the DATA field ----------------
        r_bus_in = 1'b1;                                 // start
        @(posedge r_clock); #1;
        for (int i = 0; i < 6; i++) begin                // mod=3, addr=1
            r_bus_in = (i < 2) || (i == 5);
            @(posedge r_clock); #1;
        end
        for (int i = 0; i < 20; i++) begin               // part of the data
            r_bus_in = i[0];
            @(posedge r_clock); #1;
        end
        check("midframe_busy_before_reset", 64'(w_busy), 64'd1);
        #2;
        r_reset_n = 1'b0;
        r_bus_in  = 1'b0;
        #1;
        check("midframe_reset_busy", 64'(w_busy), 64'd0);
        check("midframe_reset_data", w_data_out, 64'd0);
        check("midframe_reset_counts", 64'({w_frame_cnt, w_err_cnt}), 64'd0);
        @(posedge r_clock);
        @(negedge r_clock);
        r_reset_n = 1'b1;
        @(posedge r_clock); #1;
        send_frame(2'd2, 4'h1, 64'h0BADF00D, crc4(2'd2, 4'h1, 64'h0BADF00D),
                   v_at, e_at, n_v, n_e, busy_bad, both);
        check("post_reset_latency", 64'(v_at), 64'd43);
        check("post_reset_data", w_data_out, 64'h0BADF00D);
        check("post_reset_mod", 64'(w_mod_out), 64'd2);
        check("post_reset_frame_cnt", 64'(w_frame_cnt), 64'd1);
        idle_cycles(2);

        // ---------------- Counter saturation ----------------
        for (int i = 0; i < 260; i++) begin
            send_frame(2'd0, 4'h1, 64'(i[7:0]), crc4(2'd0, 4'h1, 64'(i[7:0])),
                       v_at, e_at, n_v, n_e, busy_bad, both);
        end
        check("sat_frame_cnt", 64'(w_frame_cnt), 64'd255);
        check("sat_last_data", w_data_out, 64'h03);
        for (int i = 0; i < 260; i++) begin
            send_frame(2'd0, 4'h1, 64'h5C, crc4(2'd0, 4'h1, 64'h5C) ^ 4'h6,
                       v_at, e_at, n_v, n_e, busy_bad, both);
        end
        check("sat_err_cnt", 64'(w_err_cnt), 64'd255);
        check("sat_last_err_pulse", 64'(e_at), 64'd19);
        check("sat_frame_cnt_held", 64'(w_frame_cnt), 64'd255);
        check("sat_data_held", w_data_out, 64'h03);
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
